// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
// Shares the register file's single write port (we3/wa3/wd3) between the
// datapath writeback and two multi-cycle auxiliary units. It also keeps a
// pending-write scoreboard so decode can stall on RAW hazards against
// registers still owed by an in-flight auxiliary operation.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   main_we/main_wa/main_wd  datapath writeback request
//   main_stall               datapath must not retire; its write is dropped
//   aux_valid[1:0]           aux write requests (bit i = unit i)
//   aux0_wa/aux0_wd          aux unit 0 destination and data
//   aux1_wa/aux1_wd          aux unit 1 destination and data
//   aux_ready[1:0]           one-hot (or zero) grant to the aux units
//   alloc_valid/alloc_reg    reserve a destination at multi-cycle issue
//   ra1, ra2                 decode source registers
//   rd1_busy, rd2_busy       source register has a pending aux write
//   we3/wa3/wd3              register file write port
module reg_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        main_we,
  input  logic [4:0]  main_wa,
  input  logic [31:0] main_wd,
  output logic        main_stall,
  input  logic [1:0]  aux_valid,
  input  logic [4:0]  aux0_wa,
  input  logic [31:0] aux0_wd,
  input  logic [4:0]  aux1_wa,
  input  logic [31:0] aux1_wd,
  output logic [1:0]  aux_ready,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_reg,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        rd1_busy,
  output logic        rd2_busy,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [31:0] pending;
  logic [31:0] pending_next;
  logic        rr;
  logic [3:0]  cnt;

  logic        any_aux;
  logic        force_aux;
  logic        sel;
  logic [4:0]  sel_wa;
  logic [31:0] sel_wd;
  logic        aux_win;
  logic        main_win;

  // Grant and port drive. The aux unit only overrides a datapath write once
  // its request has been blocked long enough; reset masks every grant so no
  // write or handshake can leak through while the state is being cleared.
  always_comb begin
    any_aux   = |aux_valid;
    force_aux = (cnt >= LIMIT);
    sel       = aux_valid[rr] ? rr : ~rr;
    sel_wa    = sel ? aux1_wa : aux0_wa;
    sel_wd    = sel ? aux1_wd : aux0_wd;

    aux_win    = !reset && any_aux && (force_aux || !main_we);
    main_win   = !reset && main_we && !aux_win;
    main_stall = aux_win && main_we;

    aux_ready = '0;
    wa3       = '0;
    wd3       = '0;
    if (aux_win) begin
      aux_ready[sel] = 1'b1;
      wa3            = sel_wa;
      wd3            = sel_wd;
    end else if (main_win) begin
      wa3 = main_wa;
      wd3 = main_wd;
    end
    // Register 0 is hardwired: the handshake still completes but nothing is written.
    we3 = (aux_win || main_win) && (wa3 != 5'd0);
  end

  // Scoreboard next state: a new reservation takes priority over a clear of
  // the same register, since the new producer's write is still outstanding.
  always_comb begin
    pending_next = pending;
    if (aux_win) begin
      pending_next[sel_wa] = 1'b0;
    end
    if (alloc_valid && (alloc_reg != 5'd0)) begin
      pending_next[alloc_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      rr      <= 1'b0;
      cnt     <= '0;
    end else begin
      pending <= pending_next;
      if (aux_win) begin
        rr <= ~sel;
      end
      // The counter measures how long the current aux request has been blocked.
      if (aux_win || !any_aux) begin
        cnt <= '0;
      end else if (cnt != 4'hF) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign rd1_busy = (ra1 != 5'd0) && pending[ra1];
  assign rd2_busy = (ra2 != 5'd0) && pending[ra2];

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 register file. It shares the register file's single write port (we3/wa3/wd3) between the single-cycle datapath's writeback and two multi-cycle auxiliary units, such as a mul/div unit and a slow load unit. It also tracks registers reserved by in-flight auxiliary operations so that decode can stall on RAW hazards. It sits between the writeback sources and reg_file, and its busy outputs feed the control unit's stall logic.

## Interface
- STARVE_LIMIT, 4: consecutive blocked cycles an auxiliary request tolerates before the datapath is forced to stall; legal range 1..15.

- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- main_we  in  1  datapath writeback enable
- main_wa  in  5  datapath destination register
- main_wd  in  32  datapath writeback data
- main_stall  out  1  datapath must not retire this cycle; its write is dropped and must be replayed
- aux_valid  in  2  write request from aux unit i (bit i)
- aux0_wa, aux1_wa  in  5 each  aux destination register
- aux0_wd, aux1_wd  in  32 each  aux write data
- aux_ready  out  2  grant to aux unit i; at most one bit set
- alloc_valid  in  1  reserve a destination at multi-cycle issue
- alloc_reg  in  5  register to reserve
- ra1, ra2  in  5  decode source registers
- rd1_busy, rd2_busy  out  1  source register has a pending aux write
- we3  out  1  to reg_file write enable
- wa3  out  5  to reg_file write address
- wd3  out  32  to reg_file write data

## Operation
- **State:**
  - pending[31:0] scoreboard.
  - rr, a 1-bit round-robin pointer indicating which aux unit is preferred.
  - cnt, a saturating 4-bit starvation counter.
  - force = (cnt >= STARVE_LIMIT), derived combinationally.
- **Aux selection:** among the asserted aux_valid bits, pick aux[rr] if it is valid, otherwise the other one.
- **Grant, evaluated combinationally each cycle:**
  - **force && main_we && |aux_valid:** the selected aux unit wins and main_stall=1.
  - **else main_we:** the datapath wins; aux_ready=0.
  - **else |aux_valid:** the selected aux unit wins.
  - **else:** the port is idle.
- **Port drive:**
  - we3=1 only when the winner's destination register is non-zero.
  - Writes to register 0 complete the handshake but are discarded (we3=0).
  - wa3 and wd3 carry the winner's address and data. When idle, all three outputs are 0.
- **Handshake:**
  - A transfer occurs when aux_valid[i] && aux_ready[i].
  - An aux unit must hold valid, wa and wd stable until its transfer completes.
  - aux_ready never depends on aux unit i withdrawing its request.
- **rr update:** on a transfer by aux unit i, rr <= ~i. Otherwise rr is unchanged.
- **cnt update:**
  - Reset to 0 on any aux transfer, or when aux_valid==0.
  - Otherwise incremented, saturating at 15.
- **Scoreboard:**
  - alloc_valid sets pending[alloc_reg]. An alloc of register 0 is ignored.
  - An aux transfer clears pending[aux_wa].
  - If alloc and clear target the same register in the same cycle, the set wins.
  - Re-allocating a register that is already pending leaves it set.
  - Datapath writes never touch the scoreboard.
- **Busy outputs:** rdN_busy = pending[raN], and 0 when raN==0.

## Timing
- The grant, port drive, main_stall and busy outputs are combinational from inputs and state; there is zero added latency to reg_file.
- The register file captures the write at the posedge that ends the grant cycle.
- Busy flags fall in the cycle after the commit edge. Decode therefore reads the new value from reg_file with no bypass.
- A blocked aux request is granted at the latest in cycle STARVE_LIMIT after it first asserts, with the first assertion cycle counted as cycle 0.
- **Reset:**
  - pending=0, rr=0, cnt=0.
  - While reset is high, we3, aux_ready and main_stall are forced to 0 regardless of the inputs.
  - Reset asserted mid-operation discards all reservations and the starvation history at the next edge.

## Test plan
- **Main write:** reset, then main_we=1, main_wa=5, main_wd=0xDEADBEEF. Required: we3=1, wa3=5, wd3=0xDEADBEEF, main_stall=0, aux_ready=00.
- **Round-robin:** main idle, both aux units valid (aux0_wa=3, aux1_wa=4) for 4 cycles. Required: aux_ready is 01, 10, 01, 10 and wa3 is 3, 4, 3, 4.
- **Starvation (STARVE_LIMIT=4):** main_we held at 1; aux0 valid with wa=7, wd=0x11 from cycle 0. Required:
  - Cycles 0–3: aux_ready=0.
  - Cycle 4: aux_ready=01, main_stall=1, wa3=7.
  - Cycle 5: main wins, main_stall=0.
- **Scoreboard:** alloc reg 9, then ra1=9. Required: rd1_busy=1 from the next cycle. Then aux1 transfers wa=9. Required: rd1_busy=1 during the commit cycle and 0 on the cycle after.
- **Register 0 and collisions:**
  - alloc reg 0. Required: rd1_busy stays 0 with ra1=0.
  - aux0 writes wa=0. Required: the handshake completes and we3=0.
  - Same-cycle alloc and commit of reg 12. Required: pending[12] remains 1.
- **Reset mid-operation:** with pending[9]=1 and cnt=4, assert reset for 1 cycle. Required: busy=0, main_stall=0, aux_ready=0, and the next aux grant goes to aux0 first.
